// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam int unsigned CNT_W = 4;
  typedef logic [CNT_W-1:0] cnt_t;

  function automatic int unsigned id_w(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority encoder: first set request at or after i_ptr wins.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [ID_W-1:0]    o_id,
  output logic               o_any
);

  always_comb begin
    int unsigned w_idx;
    o_id  = '0;
    o_any = 1'b0;
    w_idx = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = 32'(i_ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      // Constant inner index keeps the request select full-width and lint-clean.
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!o_any && (j == w_idx) && i_req[j]) begin
          o_any = 1'b1;
          o_id  = ID_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst write arbiter in front of a shared byte FIFO.
// Define FIFO_ARB_PRIO0_EN to make producer 0 strict-high-priority at arbitration.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ   = 4,
  parameter  int unsigned DATA_W    = 8,
  parameter  int unsigned MAX_BURST = 4,
  parameter  int unsigned IDLE_TO   = 8,
  localparam int unsigned ID_W      = id_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_data,
  output logic                      grant_valid,
  output logic [ID_W-1:0]           grant_id
);

  localparam cnt_t MAX_B  = cnt_t'(MAX_BURST);
  localparam cnt_t IDLE_B = cnt_t'(IDLE_TO);

  state_t            r_state;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_gid;
  logic              r_gvalid;
  cnt_t              r_beat_cnt;
  cnt_t              r_idle_cnt;

  logic [NUM_REQ-1:0] w_onehot;
  logic               w_in_burst;
  logic               w_g_valid;
  logic               w_g_last;
  logic [DATA_W-1:0]  w_g_data;
  logic               w_xfer;
  logic               w_end;
  cnt_t               w_beat_inc;
  cnt_t               w_idle_inc;
  logic [ID_W-1:0]    w_ptr_inc;
  logic [ID_W-1:0]    w_ptr_next;
  logic [NUM_REQ-1:0] w_arb_req;
  logic [ID_W-1:0]    w_arb_id;
  logic               w_arb_any;
  logic [ID_W-1:0]    w_win;
  logic               w_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .i_req (w_arb_req),
    .i_ptr (r_rr_ptr),
    .o_id  (w_arb_id),
    .o_any (w_arb_any)
  );

`ifdef FIFO_ARB_PRIO0_EN
  assign w_arb_req  = req_valid & ~NUM_REQ'(1);
  assign w_any      = req_valid[0] | w_arb_any;
  assign w_win      = req_valid[0] ? '0 : w_arb_id;
  assign w_ptr_next = (r_gid == '0) ? r_rr_ptr : w_ptr_inc;
`else
  assign w_arb_req  = req_valid;
  assign w_any      = w_arb_any;
  assign w_win      = w_arb_id;
  assign w_ptr_next = w_ptr_inc;
`endif

  // reset_n gating keeps the reset cycle write-free even though state clears only at the edge.
  assign w_in_burst = (r_state == ST_BURST) && reset_n;
  assign w_onehot   = NUM_REQ'(1) << r_gid;
  assign w_g_valid  = |(req_valid & w_onehot);
  assign w_g_last   = |(req_last & w_onehot);

  always_comb begin
    w_g_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (r_gid == ID_W'(i)) w_g_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign req_ready  = (w_in_burst && !fifo_full) ? w_onehot : '0;
  assign w_xfer     = w_in_burst && w_g_valid && !fifo_full;
  assign fifo_wr_en = w_xfer;
  assign fifo_data  = r_gvalid ? w_g_data : '0;

  assign w_beat_inc = r_beat_cnt + 1'b1;
  assign w_idle_inc = r_idle_cnt + 1'b1;
  assign w_ptr_inc  = (r_gid == ID_W'(NUM_REQ - 1)) ? '0 : r_gid + 1'b1;
  assign w_end      = w_in_burst &&
                      ((w_xfer && (w_g_last || (w_beat_inc == MAX_B))) ||
                       (!w_g_valid && (w_idle_inc == IDLE_B)));

  assign grant_valid = r_gvalid;
  assign grant_id    = r_gid;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_gid      <= '0;
      r_gvalid   <= 1'b0;
      r_beat_cnt <= '0;
      r_idle_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state    <= ST_BURST;
            r_gid      <= w_win;
            r_gvalid   <= 1'b1;
            r_beat_cnt <= '0;
            r_idle_cnt <= '0;
          end
        end
        ST_BURST: begin
          if (w_end) begin
            r_state    <= ST_IDLE;
            r_gid      <= '0;
            r_gvalid   <= 1'b0;
            r_rr_ptr   <= w_ptr_next;
            r_beat_cnt <= '0;
            r_idle_cnt <= '0;
          end else if (w_xfer) begin
            r_beat_cnt <= w_beat_inc;
            r_idle_cnt <= '0;
          end else if (!w_g_valid) begin
            r_idle_cnt <= w_idle_inc;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed + randomized bench for fifo_wr_arbiter against a cycle-level reference model.
module tb_fifo_wr_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int MB  = 4;
  localparam int ITO = 8;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_data;
  logic            grant_valid;
  logic [1:0]      grant_id;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ   (N),
    .DATA_W    (DW),
    .MAX_BURST (MB),
    .IDLE_TO   (ITO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_data   (fifo_data),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  int checks;
  int errors;

  // Producer packet buffers: {last, byte}
  logic [8:0] pbuf [N][64];
  logic [5:0] phead [N];
  logic [5:0] ptail [N];
  logic [N-1:0] en;

  // Reference model: owner -1 means no grant
  int m_owner, m_ptr, m_beats, m_idle;

  logic [7:0] wr_log[$];
  logic       wr_pat[$];
  int         dgl[$];
  int         mgl[$];
  logic       s_gv, s_prev_gv;
  logic [1:0] s_gid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int p, input logic [7:0] b, input logic last);
    pbuf[p][ptail[p]] = {last, b};
    ptail[p] = ptail[p] + 6'd1;
  endtask

  task automatic flush_all();
    for (int i = 0; i < N; i++) phead[i] = ptail[i];
  endtask

  task automatic cycle();
    logic [N-1:0]  e_rdy;
    logic          e_wr;
    logic [DW-1:0] e_dat;
    logic [8:0]    hd;
    int            nxt;
    bit            fire;
    for (int i = 0; i < N; i++) begin
      if (phead[i] != ptail[i]) begin
        hd = pbuf[i][phead[i]];
        req_valid[i]       = en[i];
        req_data[i*DW+:DW] = hd[7:0];
        req_last[i]        = hd[8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*DW+:DW] = 8'($urandom);
        req_last[i]        = 1'($urandom);
      end
    end
    #1;
    e_rdy = '0;
    e_wr  = 1'b0;
    e_dat = '0;
    if (m_owner >= 0) begin
      e_dat = req_data[m_owner*DW +: DW];
      if (reset_n && !fifo_full) begin
        e_rdy[m_owner] = 1'b1;
        e_wr           = req_valid[m_owner];
      end
    end
    chk("req_ready",   32'(req_ready),   32'(e_rdy));
    chk("fifo_wr_en",  32'(fifo_wr_en),  32'(e_wr));
    chk("fifo_data",   32'(fifo_data),   32'(e_dat));
    chk("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
    chk("grant_id",    32'(grant_id),    (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    chk("no_wr_when_full", 32'(fifo_wr_en & fifo_full), 32'd0);

    s_gv  = grant_valid;
    s_gid = grant_id;
    if (s_gv && !s_prev_gv) dgl.push_back(int'(s_gid));
    s_prev_gv = s_gv;
    wr_pat.push_back(fifo_wr_en);
    if (fifo_wr_en) wr_log.push_back(fifo_data);
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i]) phead[i] = phead[i] + 6'd1;

    if (!reset_n) begin
      m_owner = -1; m_ptr = 0; m_beats = 0; m_idle = 0;
    end else if (m_owner < 0) begin
      nxt = -1;
`ifdef FIFO_ARB_PRIO0_EN
      if (req_valid[0]) nxt = 0;
`endif
      for (int k = 0; k < N && nxt < 0; k++) begin
        int c;
        c = (m_ptr + k) % N;
`ifdef FIFO_ARB_PRIO0_EN
        if (c != 0 && req_valid[c]) nxt = c;
`else
        if (req_valid[c]) nxt = c;
`endif
      end
      if (nxt >= 0) begin
        m_owner = nxt; m_beats = 0; m_idle = 0;
        mgl.push_back(nxt);
      end
    end else begin
      fire = 1'b0;
      if (e_wr) begin
        m_beats++;
        m_idle = 0;
        fire = req_last[m_owner] || (m_beats == MB);
      end else if (!req_valid[m_owner]) begin
        m_idle++;
        fire = (m_idle == ITO);
      end
      if (fire) begin
`ifdef FIFO_ARB_PRIO0_EN
        if (m_owner != 0) m_ptr = (m_owner + 1) % N;
`else
        m_ptr = (m_owner + 1) % N;
`endif
        m_owner = -1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int         s2_exp[5];
    logic [7:0] s1_exp[3];
    logic [7:0] s3b[4];
    int         cnt;

    checks = 0; errors = 0;
    m_owner = -1; m_ptr = 0; m_beats = 0; m_idle = 0;
    s_prev_gv = 1'b0;
    en = '0; fifo_full = 1'b0; reset_n = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0;
    for (int i = 0; i < N; i++) begin phead[i] = '0; ptail[i] = '0; end
    @(posedge clk);
    @(negedge clk);

    // Reset state
    cycle(); cycle();
    chk("rst_state",  32'(dut.r_state),  32'd0);
    chk("rst_rr_ptr", 32'(dut.r_rr_ptr), 32'd0);
    reset_n = 1'b1;

    // Single producer 2 packet
    s1_exp[0] = 8'hA1; s1_exp[1] = 8'hA2; s1_exp[2] = 8'hA3;
    wr_log.delete(); dgl.delete();
    push(2, 8'hA1, 1'b0); push(2, 8'hA2, 1'b0); push(2, 8'hA3, 1'b1);
    en = 4'b0100;
    repeat (6) cycle();
    chk("s1_ngrant", 32'(dgl.size()), 32'd1);
    if (dgl.size() > 0) chk("s1_grant_id", 32'(dgl[0]), 32'd2);
    chk("s1_nwr", 32'(wr_log.size()), 32'd3);
    for (int i = 0; i < 3 && i < wr_log.size(); i++) chk("s1_byte", 32'(wr_log[i]), 32'(s1_exp[i]));
    chk("s1_rr_ptr", 32'(dut.r_rr_ptr), 32'd3);

    // All producers continuously valid, MAX_BURST bursts
    en = '0; reset_n = 1'b0; cycle(); reset_n = 1'b1;
    for (int p = 0; p < N; p++)
      for (int b = 0; b < 20; b++) push(p, 8'($urandom), 1'b0);
    s2_exp[0] = 0; s2_exp[1] = 1; s2_exp[2] = 2; s2_exp[3] = 3; s2_exp[4] = 0;
    en = 4'b1111; wr_log.delete(); dgl.delete(); wr_pat.delete();
    repeat (25) cycle();
    chk("s2_ngrant", 32'(dgl.size()), 32'd5);
    for (int i = 0; i < 5 && i < dgl.size(); i++) chk("s2_order", 32'(dgl[i]), 32'(s2_exp[i]));
    chk("s2_nwr", 32'(wr_log.size()), 32'd20);
    for (int i = 0; i < wr_pat.size(); i++) chk("s2_wr_pattern", 32'(wr_pat[i]), 32'((i % 5) != 0));
    en = '0; flush_all(); cycle(); cycle();

    // Producer 1 burst with fifo_full stall
    for (int i = 0; i < 4; i++) begin
      s3b[i] = 8'($urandom);
      push(1, s3b[i], 1'(i == 3));
    end
    en = 4'b0010; wr_log.delete();
    repeat (3) cycle();
    fifo_full = 1'b1;
    repeat (3) cycle();
    chk("s3_beat_hold", 32'(dut.r_beat_cnt), 32'd2);
    fifo_full = 1'b0;
    repeat (3) cycle();
    chk("s3_nwr", 32'(wr_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < wr_log.size(); i++) chk("s3_byte", 32'(wr_log[i]), 32'(s3b[i]));
    en = '0;

    // Producer 3 goes quiet after one beat; idle timeout then producer 0
    push(3, 8'($urandom), 1'b0); push(3, 8'($urandom), 1'b0);
    push(0, 8'($urandom), 1'b1);
    en = 4'b1001; dgl.delete();
    cycle(); cycle();
    en = 4'b0001;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (s_gv && s_gid == 2'd3) cnt++;
      else break;
    end
    chk("s4_idle_to_cycles", 32'(cnt), 32'(ITO));
    cycle(); cycle();
    chk("s4_ngrant", 32'(dgl.size()), 32'd2);
    if (dgl.size() > 1) chk("s4_next_grant", 32'(dgl[1]), 32'd0);
    flush_all(); en = '0; cycle();

    // Reset in the middle of a producer 2 burst
    for (int i = 0; i < 4; i++) push(2, 8'($urandom), 1'b0);
    en = 4'b0100;
    repeat (3) cycle();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    chk("s5_state",   32'(dut.r_state),  32'd0);
    chk("s5_rr_ptr",  32'(dut.r_rr_ptr), 32'd0);
    chk("s5_gvalid",  32'(grant_valid),  32'd0);
    chk("s5_wr_en",   32'(fifo_wr_en),   32'd0);
    push(1, 8'($urandom), 1'b0); push(1, 8'($urandom), 1'b1);
    en = 4'b0110; dgl.delete();
    repeat (3) cycle();
    if (dgl.size() > 0) chk("s5_winner", 32'(dgl[0]), 32'd1);
    else chk("s5_winner_missing", 32'(dgl.size()), 32'd1);
    flush_all(); en = '0;
    repeat (12) cycle();

    // Producers 0 and 2 contending
    dgl.delete(); mgl.delete();
    for (int b = 0; b < 12; b++) begin
      push(0, 8'($urandom), 1'(b % 2));
      push(2, 8'($urandom), 1'(b % 2));
    end
    en = 4'b0101;
    repeat (30) cycle();
    chk("s6_ngrant", 32'(dgl.size()), 32'(mgl.size()));
    for (int i = 0; i < dgl.size() && i < mgl.size(); i++) chk("s6_grant_seq", 32'(dgl[i]), 32'(mgl[i]));
    flush_all(); en = '0;
    repeat (12) cycle();

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      en        = 4'($urandom);
      fifo_full = ($urandom_range(0, 3) == 0);
      reset_n   = ($urandom_range(0, 99) != 0);
      for (int p = 0; p < N; p++)
        if ($urandom_range(0, 2) == 0 && 6'(ptail[p] - phead[p]) < 6'd60)
          push(p, 8'($urandom), 1'($urandom_range(0, 3) == 0));
      cycle();
    end
    reset_n = 1'b1; fifo_full = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
